cart_bus_arbiter: RTL and testbench
===================================

# cart_bus_arbiter

Sequences ownership of the cartridge ROM/RAM bus between the Game Boy and an on-cart loader port, which programs flash and backs up save RAM. On loader request it holds the Game Boy in reset and lets the bus settle. It then hands the memory address, data and strobes to the loader and times each read or write strobe. On release it returns the bus and lets the Game Boy run again. It sits beside the bank-mapping logic; an external mux selected by MEM_SEL chooses between mapper outputs and this block's outputs.

## Interface
Parameters:
- SETTLE_CYC, 16: cycles between GB_RST assert and LD_GNT; also cycles between bus return and GB_RST deassert.
- PULSE_CYC, 4: cycles MEM_WE_N/MEM_OE_N stay low per access (≥1).
- TIMEOUT_CYC, 1024: idle-grant cycles before forced release (only with ARB_TIMEOUT_EN).

Ports:
- CLK  in  1  system clock. Single clock domain; every flop is clocked by CLK.
- RST  in  1  synchronous reset, active-high.
- GB_RST  out  1  Game Boy reset, active-low (1 = run).
- LD_REQ  in  1  level; loader requests a bus session.
- LD_GNT  out  1  loader owns bus.
- LD_STB  in  1  one-cycle access start.
- LD_WE  in  1  1 = write, 0 = read; sampled with LD_STB.
- LD_SEL  in  1  0 = ROM, 1 = RAM; sampled with LD_STB.
- LD_ADDR  in  23  byte address; sampled with LD_STB.
- LD_WDATA  in  8  write data; sampled with LD_STB.
- LD_RDATA  out  8  read data; holds the last read.
- LD_DONE  out  1  one-cycle access-complete pulse.
- MEM_SEL  out  1  0 = mapper drives memory, 1 = this block.
- MEM_A  out  23  memory address.
- MEM_DO  out  8  memory write data.
- MEM_DOE  out  1  data output enable.
- MEM_DI  in  8  memory read data.
- MEM_ROM_CS_N, MEM_RAM_CS_N, MEM_WE_N, MEM_OE_N  out  1 each  active-low chip selects and strobes.

## Operation
- States: IDLE, HOLD, GRANT, SETUP, STROBE, RECOVER, RELEASE.
- IDLE
  - GB_RST=1, MEM_SEL=0.
  - LD_REQ=1 → HOLD.
- HOLD
  - GB_RST=0; count SETTLE_CYC.
  - Then MEM_SEL=1 and LD_GNT=1 → GRANT.
  - LD_REQ dropping during HOLD → RELEASE.
- GRANT
  - LD_STB captures WE, SEL, ADDR and WDATA → SETUP.
  - LD_REQ=0 with no LD_STB → RELEASE.
  - LD_STB and LD_REQ=0 in the same cycle: the access is served, then release.
- SETUP (1 cycle)
  - MEM_A driven; selected CS_N=0.
  - Write: MEM_DO driven and MEM_DOE=1.
- STROBE (PULSE_CYC cycles)
  - MEM_WE_N=0 for a write, MEM_OE_N=0 for a read.
  - Read: MEM_DI is registered into LD_RDATA on the last STROBE cycle.
- RECOVER (1 cycle)
  - Strobes=1, CS_N=1; MEM_DOE stays 1 for a write (data hold).
  - LD_DONE=1.
  - Next state GRANT; RELEASE if LD_REQ=0.
- RELEASE
  - LD_GNT=0, MEM_DOE=0, MEM_SEL=0 on entry.
  - GB_RST stays 0 for SETTLE_CYC, then GB_RST=1 → IDLE.
  - LD_REQ=1 during RELEASE is held off until IDLE.
- Ignored strobes: LD_STB outside GRANT, including while an access is in progress, produces no LD_DONE.
- LD_REQ dropping mid-access: the access completes, then RELEASE.
- Counters are sized to the parameters.

## Timing
- Reset values: GB_RST=1, LD_GNT=0, LD_DONE=0, LD_RDATA=0, MEM_SEL=0, MEM_A=0, MEM_DO=0, MEM_DOE=0; all *_N outputs=1; state IDLE.
- RST asserted mid-operation: all outputs take their reset values on the next edge, including aborting a strobe.
- All outputs are registered.
- Request to grant: LD_REQ sampled at edge 0 → GB_RST=0 after edge 1 → LD_GNT=1 after edge 1+SETTLE_CYC.
- Access latency: LD_STB at edge n → LD_DONE high in the cycle after edge n+PULSE_CYC+2.
- Next LD_STB is accepted from the cycle after LD_DONE.
- Release: LD_REQ low at edge m (state GRANT) → LD_GNT=0 and MEM_SEL=0 after edge m+1 → GB_RST=1 after edge m+1+SETTLE_CYC.

## Configuration
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - An idle counter runs in GRANT and clears on LD_STB.
  - When it reaches TIMEOUT_CYC the block forces RELEASE even if LD_REQ=1.
  - A new session then requires LD_REQ low for ≥1 cycle.
- Undefined: no counter; a session lasts until LD_REQ drops; TIMEOUT_CYC is unused.

## Test plan
- Reset, then LD_REQ=1 with SETTLE_CYC=16 → GB_RST=0 next cycle; LD_GNT=1 exactly 17 cycles after request; MEM_SEL=1.
- Write ROM: ADDR=0x7F_C000, WDATA=0xA5 → MEM_ROM_CS_N=0, MEM_DO=0xA5, MEM_WE_N low 4 cycles, MEM_DOE held through RECOVER, LD_DONE 6 cycles after STB.
- Read RAM: ADDR=0x01_E000 with MEM_DI=0x3C → MEM_RAM_CS_N=0, MEM_OE_N low 4 cycles, LD_RDATA=0x3C with LD_DONE.
- LD_STB while busy, and LD_REQ dropped mid-STROBE → extra STB produces no DONE; access completes; LD_GNT=0; GB_RST=1 16 cycles later.
- RST pulsed during STROBE → next cycle all strobes and CS_N=1, MEM_SEL=0, GB_RST=1, LD_GNT=0.
- ARB_TIMEOUT_EN with TIMEOUT_CYC=8, LD_REQ held high and no STB → forced release after 8 idle cycles; no re-grant until LD_REQ toggles low then high.

Source files
------------

// File: rtl/cart_bus_arbiter.sv
// Cartridge bus arbiter: parks the Game Boy in reset, lends the ROM/RAM bus to the loader
// port and times each strobe. Define ARB_TIMEOUT_EN to force release of an idle grant.
module cart_bus_arbiter #(
  parameter int unsigned SETTLE_CYC  = 16,
  parameter int unsigned PULSE_CYC   = 4,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic        CLK,
  input  logic        RST,
  output logic        GB_RST,
  input  logic        LD_REQ,
  output logic        LD_GNT,
  input  logic        LD_STB,
  input  logic        LD_WE,
  input  logic        LD_SEL,
  input  logic [22:0] LD_ADDR,
  input  logic [7:0]  LD_WDATA,
  output logic [7:0]  LD_RDATA,
  output logic        LD_DONE,
  output logic        MEM_SEL,
  output logic [22:0] MEM_A,
  output logic [7:0]  MEM_DO,
  output logic        MEM_DOE,
  input  logic [7:0]  MEM_DI,
  output logic        MEM_ROM_CS_N,
  output logic        MEM_RAM_CS_N,
  output logic        MEM_WE_N,
  output logic        MEM_OE_N
);

  typedef enum logic [2:0] {
    IDLE, HOLD, GRANT, SETUP, STROBE, RECOVER, RELEASE
  } state_t;

  localparam int unsigned CNT_MAX = (SETTLE_CYC > PULSE_CYC) ? SETTLE_CYC : PULSE_CYC;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] PULSE_LAST  = CNT_W'(PULSE_CYC - 1);

  if (SETTLE_CYC == 0 || PULSE_CYC == 0 || TIMEOUT_CYC == 0) begin : g_param_check
    $error("cart_bus_arbiter: cycle parameters must be at least 1");
  end

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             timeout;
  logic             req_ok;

  logic             acc_we, acc_sel;
  logic [22:0]      acc_addr;
  logic [7:0]       acc_wdata;

  logic gb_rst_nxt, gnt_nxt, done_nxt, doe_nxt, busy;
  logic rom_cs_n_nxt, ram_cs_n_nxt, we_n_nxt, oe_n_nxt;

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned IDLE_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYC - 1);

  logic [IDLE_W-1:0] idle_cnt;
  logic              req_block;

  // After a forced release the loader must drop LD_REQ before it can start a new session.
  always_ff @(posedge CLK) begin
    if (RST) begin
      idle_cnt  <= '0;
      req_block <= 1'b0;
    end else begin
      if (state == GRANT && !LD_STB) idle_cnt <= idle_cnt + 1'b1;
      else                           idle_cnt <= '0;
      if (!LD_REQ)      req_block <= 1'b0;
      else if (timeout) req_block <= 1'b1;
    end
  end

  assign timeout = (state == GRANT) && !LD_STB && (idle_cnt == IDLE_LAST);
  assign req_ok  = LD_REQ && !req_block;
`else
  assign timeout = 1'b0;
  assign req_ok  = LD_REQ;
`endif

  // NOTE: sequential state uses <= so every flop samples the pre-edge values of the others.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (state_nxt != state)                     cnt <= '0;
      else if (state inside {HOLD, STROBE, RELEASE}) cnt <= cnt + 1'b1;
    end
  end

  // NOTE: payload capture registers carry no reset; they are only read after being loaded.
  always_ff @(posedge CLK) begin
    if (state == GRANT && LD_STB) begin
      acc_we    <= LD_WE;
      acc_sel   <= LD_SEL;
      acc_addr  <= LD_ADDR;
      acc_wdata <= LD_WDATA;
    end
  end

  // NOTE: every signal gets a default first so no path through the case infers a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_ok) state_nxt = HOLD;
      HOLD: begin
        if (!LD_REQ)                 state_nxt = RELEASE;
        else if (cnt == SETTLE_LAST) state_nxt = GRANT;
      end
      GRANT: begin
        if (LD_STB)                  state_nxt = SETUP;
        else if (!LD_REQ || timeout) state_nxt = RELEASE;
      end
      SETUP:   state_nxt = STROBE;
      STROBE:  if (cnt == PULSE_LAST) state_nxt = RECOVER;
      RECOVER: state_nxt = LD_REQ ? GRANT : RELEASE;
      RELEASE: if (cnt == SETTLE_LAST) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase

    // Outputs are decoded from the current state and registered, so they trail it by one cycle.
    busy         = state inside {SETUP, STROBE};
    gb_rst_nxt   = (state == IDLE);
    gnt_nxt      = state inside {GRANT, SETUP, STROBE, RECOVER};
    done_nxt     = (state == RECOVER);
    doe_nxt      = acc_we && (state inside {SETUP, STROBE, RECOVER});
    rom_cs_n_nxt = !(busy && !acc_sel);
    ram_cs_n_nxt = !(busy && acc_sel);
    we_n_nxt     = !(state == STROBE && acc_we);
    oe_n_nxt     = !(state == STROBE && !acc_we);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      GB_RST       <= 1'b1;
      LD_GNT       <= 1'b0;
      LD_DONE      <= 1'b0;
      LD_RDATA     <= '0;
      MEM_SEL      <= 1'b0;
      MEM_A        <= '0;
      MEM_DO       <= '0;
      MEM_DOE      <= 1'b0;
      MEM_ROM_CS_N <= 1'b1;
      MEM_RAM_CS_N <= 1'b1;
      MEM_WE_N     <= 1'b1;
      MEM_OE_N     <= 1'b1;
    end else begin
      GB_RST       <= gb_rst_nxt;
      LD_GNT       <= gnt_nxt;
      LD_DONE      <= done_nxt;
      MEM_SEL      <= gnt_nxt;
      MEM_DOE      <= doe_nxt;
      MEM_ROM_CS_N <= rom_cs_n_nxt;
      MEM_RAM_CS_N <= ram_cs_n_nxt;
      MEM_WE_N     <= we_n_nxt;
      MEM_OE_N     <= oe_n_nxt;
      if (state == SETUP) begin
        MEM_A <= acc_addr;
        if (acc_we) MEM_DO <= acc_wdata;
      end
      // RECOVER is the last cycle MEM_OE_N is low on the pins, so MEM_DI is sampled here.
      if (state == RECOVER && !acc_we) LD_RDATA <= MEM_DI;
    end
  end

endmodule

// File: tb/tb_cart_bus_arbiter.sv
// Bench for cart_bus_arbiter: table of loader accesses scored against a DONE queue, plus
// sequences for session open/close, busy strobes, mid-access release, abort and timeout.
`timescale 1ns/1ps
module tb_cart_bus_arbiter;

  localparam int SETTLE  = 16;
  localparam int PULSE   = 4;
  localparam int TIMEOUT = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        GB_RST, LD_GNT, LD_DONE, MEM_SEL, MEM_DOE;
  logic        LD_REQ, LD_STB, LD_WE, LD_SEL;
  logic [22:0] LD_ADDR, MEM_A;
  logic [7:0]  LD_WDATA, LD_RDATA, MEM_DO, MEM_DI;
  logic        MEM_ROM_CS_N, MEM_RAM_CS_N, MEM_WE_N, MEM_OE_N;

  always #5 clk = ~clk;

  cart_bus_arbiter #(.SETTLE_CYC(SETTLE), .PULSE_CYC(PULSE), .TIMEOUT_CYC(TIMEOUT)) dut (
    .CLK(clk), .RST(rst), .GB_RST(GB_RST), .LD_REQ(LD_REQ), .LD_GNT(LD_GNT),
    .LD_STB(LD_STB), .LD_WE(LD_WE), .LD_SEL(LD_SEL), .LD_ADDR(LD_ADDR),
    .LD_WDATA(LD_WDATA), .LD_RDATA(LD_RDATA), .LD_DONE(LD_DONE), .MEM_SEL(MEM_SEL),
    .MEM_A(MEM_A), .MEM_DO(MEM_DO), .MEM_DOE(MEM_DOE), .MEM_DI(MEM_DI),
    .MEM_ROM_CS_N(MEM_ROM_CS_N), .MEM_RAM_CS_N(MEM_RAM_CS_N),
    .MEM_WE_N(MEM_WE_N), .MEM_OE_N(MEM_OE_N)
  );

  typedef struct {
    logic        we;
    logic        sel;
    logic [22:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  di;
  } vec_t;

  typedef struct {
    logic [7:0] rdata;
    int         done_edge;
  } exp_t;

  int         checks = 0;
  int         errors = 0;
  int         edge_cnt = 0;
  int         done_total = 0;
  int         pushed_total = 0;
  exp_t       sb_q[$];
  exp_t       sb_e;
  logic [7:0] model_rd = 8'h00;
  logic       gnt_hist [0:15];
  vec_t       vecs [6];
  int         e0, d, k, hi, lows, guard, rst_high, any_gnt;

  always @(posedge clk) edge_cnt++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard side: each LD_DONE pops one expected access.
  always @(negedge clk) begin
    if (LD_DONE) begin
      done_total++;
      if (sb_q.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        sb_e = sb_q.pop_front();
        check("done_rdata", LD_RDATA, sb_e.rdata);
        check("done_edge", edge_cnt, sb_e.done_edge);
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_gb_rst"}, GB_RST, 1);
    check({tag, "_ld_gnt"}, LD_GNT, 0);
    check({tag, "_ld_done"}, LD_DONE, 0);
    check({tag, "_ld_rdata"}, LD_RDATA, 0);
    check({tag, "_mem_sel"}, MEM_SEL, 0);
    check({tag, "_mem_a"}, MEM_A, 0);
    check({tag, "_mem_do"}, MEM_DO, 0);
    check({tag, "_mem_doe"}, MEM_DOE, 0);
    check({tag, "_n_outs"}, {MEM_ROM_CS_N, MEM_RAM_CS_N, MEM_WE_N, MEM_OE_N}, 4'hF);
  endtask

  // Called at a negedge; leaves at the negedge after the sampling edge with LD_STB low.
  task automatic start_stb(input vec_t v, input bit served);
    exp_t e;
    LD_STB = 1'b1; LD_WE = v.we; LD_SEL = v.sel; LD_ADDR = v.addr;
    LD_WDATA = v.wdata; MEM_DI = v.di;
    if (served) begin
      if (!v.we) model_rd = v.di;
      e.rdata     = model_rd;
      e.done_edge = edge_cnt + 1 + PULSE + 2;
      sb_q.push_back(e);
      pushed_total++;
    end
    @(negedge clk);
    LD_STB = 1'b0;
  endtask

  task automatic run_access(input vec_t v, input string tag, input int stray_at, input int drop_at);
    int cs_cnt = 0, other_cs = 0, strb_cnt = 0, other_strb = 0, doe_cnt = 0;
    logic [22:0] a_seen = '0;
    logic [7:0]  d_seen = '0;
    logic        doe_at_done = 1'b0;
    bit          seen = 0;
    logic        cs_n, cs_n_other, strb_n, strb_n_other;
    start_stb(v, 1);
    for (int j = 0; j <= PULSE + 3; j++) begin
      if (j > 0) @(negedge clk);
      cs_n         = v.sel ? MEM_RAM_CS_N : MEM_ROM_CS_N;
      cs_n_other   = v.sel ? MEM_ROM_CS_N : MEM_RAM_CS_N;
      strb_n       = v.we ? MEM_WE_N : MEM_OE_N;
      strb_n_other = v.we ? MEM_OE_N : MEM_WE_N;
      if (!cs_n) begin
        cs_cnt++;
        if (!seen) begin a_seen = MEM_A; d_seen = MEM_DO; seen = 1; end
      end
      if (!cs_n_other)   other_cs++;
      if (!strb_n)       strb_cnt++;
      if (!strb_n_other) other_strb++;
      if (MEM_DOE)       doe_cnt++;
      if (j == PULSE + 2) doe_at_done = MEM_DOE;
      gnt_hist[j] = LD_GNT;
      LD_STB = (j == stray_at);
      if (j == drop_at) LD_REQ = 1'b0;
    end
    LD_STB = 1'b0;
    check($sformatf("%s_cs_cycles", tag), cs_cnt, PULSE + 1);
    check($sformatf("%s_other_cs", tag), other_cs, 0);
    check($sformatf("%s_strobe_cycles", tag), strb_cnt, PULSE);
    check($sformatf("%s_other_strobe", tag), other_strb, 0);
    check($sformatf("%s_mem_a", tag), a_seen, v.addr);
    if (v.we) check($sformatf("%s_mem_do", tag), d_seen, v.wdata);
    check($sformatf("%s_doe_cycles", tag), doe_cnt, v.we ? PULSE + 2 : 0);
    check($sformatf("%s_doe_at_done", tag), doe_at_done, v.we);
  endtask

  task automatic open_session(input bit stray_in_hold);
    int s0, first_low = -1, grant_edge = -1;
    LD_REQ = 1'b1;
    s0 = edge_cnt + 1;
    for (int n = 0; n < 4 * SETTLE; n++) begin
      @(negedge clk);
      LD_STB = stray_in_hold && (edge_cnt == s0 + 4);
      if (!GB_RST && first_low < 0) first_low = edge_cnt - s0;
      if (LD_GNT) begin grant_edge = edge_cnt - s0; break; end
    end
    LD_STB = 1'b0;
    check("gb_rst_low_edge", first_low, 1);
    check("grant_edge", grant_edge, SETTLE + 1);
    check("mem_sel_at_grant", MEM_SEL, 1);
  endtask

  task automatic close_session(input bit rereq);
    int m, gnt_low = -1, sel_low = -1, run_edge = -1, regrant = -1;
    LD_REQ = 1'b0;
    m = edge_cnt + 1;
    for (int n = 0; n < 6 * SETTLE; n++) begin
      @(negedge clk);
      if (rereq && edge_cnt == m + 3) LD_REQ = 1'b1;
      if (!LD_GNT && gnt_low < 0)  gnt_low  = edge_cnt - m;
      if (!MEM_SEL && sel_low < 0) sel_low  = edge_cnt - m;
      if (GB_RST && run_edge < 0)  run_edge = edge_cnt - m;
      if (!rereq && run_edge >= 0) break;
      if (rereq && LD_GNT && gnt_low >= 0) begin regrant = edge_cnt - m; break; end
    end
    check("release_gnt_edge", gnt_low, 1);
    check("release_sel_edge", sel_low, 1);
    check("release_gb_run_edge", run_edge, SETTLE + 1);
    if (rereq) check("regrant_after_holdoff", regrant, 2 * SETTLE + 2);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not reach its summary");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0] = '{we: 1'b1, sel: 1'b0, addr: 23'h7F_C000, wdata: 8'hA5, di: 8'hEE};
    vecs[1] = '{we: 1'b0, sel: 1'b1, addr: 23'h01_E000, wdata: 8'h00, di: 8'h3C};
    vecs[2] = '{we: 1'b1, sel: 1'b1, addr: 23'h00_0123, wdata: 8'h5A, di: 8'hEE};
    vecs[3] = '{we: 1'b0, sel: 1'b0, addr: 23'h00_0000, wdata: 8'h00, di: 8'hFF};
    vecs[4] = '{we: 1'b0, sel: 1'b1, addr: 23'h7F_FFFF, wdata: 8'h00, di: 8'h81};
    vecs[5] = '{we: 1'b1, sel: 1'b0, addr: 23'h40_0001, wdata: 8'h00, di: 8'h11};

    rst = 1'b1; LD_REQ = 1'b0; LD_STB = 1'b0; LD_WE = 1'b0; LD_SEL = 1'b0;
    LD_ADDR = '0; LD_WDATA = '0; MEM_DI = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Strobe while idle must be ignored.
    LD_STB = 1'b1;
    @(negedge clk);
    LD_STB = 1'b0;
    repeat (10) @(negedge clk);

    open_session(1);
    for (int i = 0; i < 6; i++) run_access(vecs[i], $sformatf("acc%0d", i), -1, -1);
    check("rdata_holds_last_read", LD_RDATA, model_rd);

    close_session(1);

    // Busy strobe during STROBE plus request dropped mid-access.
    run_access(vecs[1], "busy", 2, 3);
    check("gnt_held_through_done", gnt_hist[PULSE + 2], 1);
    check("gnt_low_after_drop", gnt_hist[PULSE + 3], 0);
    check("mem_sel_low_after_drop", MEM_SEL, 0);
    k = 0;
    while (!GB_RST && k < 4 * SETTLE) begin @(negedge clk); k++; end
    check("gb_run_after_drop", k, SETTLE);

    // Request withdrawn while still settling.
    LD_REQ = 1'b1;
    e0 = edge_cnt + 1;
    repeat (6) @(negedge clk);
    check("gb_rst_low_in_hold", GB_RST, 0);
    LD_REQ = 1'b0;
    d = edge_cnt + 1;
    rst_high = -1; any_gnt = 0;
    for (int n = 0; n < 4 * SETTLE; n++) begin
      @(negedge clk);
      if (LD_GNT) any_gnt++;
      if (GB_RST) begin rst_high = edge_cnt - d; break; end
    end
    check("hold_drop_no_grant", any_gnt, 0);
    check("hold_drop_gb_run_edge", rst_high, SETTLE + 1);

    // Synchronous reset in the middle of a strobe.
    open_session(0);
    start_stb(vecs[1], 1);
    repeat (3) @(negedge clk);
    check("oe_low_before_abort", MEM_OE_N, 0);
    rst = 1'b1; LD_REQ = 1'b0;
    @(negedge clk);
    check_reset_outputs("abort");
    rst = 1'b0;
    sb_q.delete();
    pushed_total--;
    model_rd = 8'h00;
    repeat (4) @(negedge clk);

`ifdef ARB_TIMEOUT_EN
    open_session(0);
    hi = 0; guard = 0;
    while (LD_GNT && guard < 4 * TIMEOUT) begin hi++; guard++; @(negedge clk); end
    check("timeout_grant_len", hi, TIMEOUT);
    guard = 0;
    while (!GB_RST && guard < 4 * SETTLE) begin guard++; @(negedge clk); end
    check("timeout_gb_run", GB_RST, 1);
    lows = 0;
    for (int n = 0; n < 3 * SETTLE; n++) begin
      @(negedge clk);
      if (!GB_RST || LD_GNT) lows++;
    end
    check("no_regrant_while_req_high", lows, 0);
    LD_REQ = 1'b0;
    @(negedge clk);
    open_session(0);
    close_session(0);
`else
    open_session(0);
    repeat (3 * TIMEOUT) @(negedge clk);
    check("grant_kept_without_timeout", LD_GNT, 1);
    close_session(0);
`endif

    repeat (4) @(negedge clk);
    check("scoreboard_empty", sb_q.size(), 0);
    check("done_count", done_total, pushed_total);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
